ecap5_spi_target: RTL and testbench
===================================

# ecap5_spi_target

SPI mode-0 target (slave) that answers the SPI initiator inside `ecap5_dwbspi`. It exposes a small byte-wide register file through a command/address/data framing protocol, and provides a local read port for the surrounding logic. It sits at the far end of the SPI link. On silicon it stands in for an external peripheral; in the benches it serves as the loop-back responder.

## Interface
- `DEPTH`, 16: number of 8-bit registers. Must be a power of two, 2..256.
- `clk_i`  in  1  system clock; all logic is clocked on the rising edge.
- `rst_i`  in  1  reset; one clock, asynchronous and active-high.
- `spi_sclk_i`  in  1  SPI clock from the initiator; idles low (CPOL=0).
- `spi_cs_n_i`  in  1  chip select, active low.
- `spi_mosi_i`  in  1  serial data from the initiator, MSB first.
- `spi_miso_o`  out  1  serial data to the initiator, MSB first.
- `spi_miso_oe_o`  out  1  high while selected; the pad drives `spi_miso_o` only when this is high.
- `loc_adr_i`  in  log2(DEPTH)  local read index.
- `loc_dat_o`  out  8  combinational read of `regs[loc_adr_i]`.
- `wr_stb_o`  out  1  one-cycle pulse on each register write.
- `cmd_err_o`  out  1  one-cycle pulse when an unknown command byte is received.

## Operation
- Input path:
  - `spi_sclk_i`, `spi_cs_n_i` and `spi_mosi_i` each pass through a 2-flop synchronizer.
  - Rising and falling edges of SCLK are detected on the synchronized value, compared against a third delay flop.
- Sampling: MOSI is sampled into `rx_shift` on a detected SCLK rising edge, with `bit_cnt` 0..7 incrementing.
- Byte completion: a byte completes on the rising edge where `bit_cnt`==7; `bit_cnt` then wraps to 0.
- MISO:
  - `spi_miso_o` = `tx_shift[7]`.
  - On a detected SCLK falling edge with `bit_cnt`!=0, `tx_shift` shifts left by one.
  - `tx_shift` is reloaded at byte completion, so the MSB is valid before the first rising edge of the next byte.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE → CMD on the synchronized CS falling edge; `bit_cnt`<=0 and `tx_shift`<=8'h00.
- CMD byte completion:
  - 8'h02 → ADDR, with `wr_mode`<=1.
  - 8'h03 → ADDR, with `wr_mode`<=0.
  - Any other value → IGNORE, with a `cmd_err_o` pulse.
- ADDR byte completion:
  - `addr`<=`rx` byte, taking the low log2(DEPTH) bits.
  - In read mode, `tx_shift`<=`regs[addr]`, using the new address.
  - Next state is DATA.
- DATA byte completion, write mode: `regs[addr]`<=`rx` byte, `wr_stb_o` pulses, `addr`<=`addr`+1.
- DATA byte completion, read mode: `addr`<=`addr`+1 and `tx_shift`<=`regs[addr+1]`.
- Address arithmetic is modulo DEPTH, so the address wraps from DEPTH-1 to 0.
- IGNORE: shifts continue, nothing is written, and MISO sends 8'h00.
- In CMD and ADDR, MISO sends 8'h00.
- Synchronized CS rising edge, from any state → IDLE:
  - The partial byte is discarded with no write and no strobe.
  - `bit_cnt`<=0.
- If a CS rising edge and an SCLK edge are detected in the same cycle, CS wins.
- `spi_miso_oe_o` = synchronized CS low. `spi_miso_o` is forced to 0 whenever OE is low.
- A register write and a local read of the same index in the same cycle: `loc_dat_o` shows the old value, and the new value appears the next cycle.

## Timing
- Reset values:
  - `regs` all 8'h00.
  - FSM in IDLE, `bit_cnt`=0, `tx_shift`=0.
  - `spi_miso_o`=0, `spi_miso_oe_o`=0, `wr_stb_o`=0, `cmd_err_o`=0.
  - `loc_dat_o`=8'h00.
- Reset mid-frame:
  - Aborts the frame immediately and returns to IDLE.
  - After release, the target waits for a fresh CS falling edge, even if CS is still low.
- Input-pin to edge detection latency is 3 `clk_i` cycles.
- `wr_stb_o` asserts 1 cycle after the detected 8th rising edge of a data byte; `regs` updates in that same cycle.
- MISO update latency is 3 `clk_i` cycles after the SCLK falling edge at the pin.
- Required ratio: f(`clk_i`) ≥ 8 × f(SCLK).
- CS setup to the first SCLK edge and hold after the last SCLK edge: ≥4 `clk_i` cycles each.
- Back-to-back frames need CS high for ≥4 `clk_i` cycles.

## Test plan
- Write burst: CS low, send 02 05 A1 B2 C3, CS high.
  - Expect `regs[5..7]` = A1,B2,C3.
  - Expect exactly 3 `wr_stb_o` pulses.
  - Expect `loc_dat_o`=B2 with `loc_adr_i`=6.
- Read burst after the write burst: send 03 05 00 00 00.
  - MISO bytes captured on rising edges read 00 00 A1 B2 C3.
  - OE is high only while CS is low.
- Wrap-around, DEPTH=16:
  - Write 02 0F 11 22 → `regs[15]`=11 and `regs[0]`=22.
  - Read 03 0F xx xx returns 11 22.
- Bad command: send 7E 03 44.
  - Expect one `cmd_err_o` pulse, no `wr_stb_o`, MISO all zero, no register changes.
- Abort:
  - Send 02 03 then 5 bits of a data byte, then CS high → `regs[3]` unchanged, no strobe.
  - Next frame 03 03 00 returns the old value.
- Reset mid-read: assert `rst_i` during the DATA byte of a read.
  - All outputs go to 0 asynchronously and `regs` clear to 00.
  - Further SCLK with CS held low produces no writes until CS cycles high then low.

Source files
------------

// File: rtl/ecap5_spi_target.sv
// SPI mode-0 target exposing a byte-wide register file through a
// command / address / data framing, plus a combinational local read port.
module ecap5_spi_target #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     spi_sclk_i,
  input  logic                     spi_cs_n_i,
  input  logic                     spi_mosi_i,
  output logic                     spi_miso_o,
  output logic                     spi_miso_oe_o,
  input  logic [$clog2(DEPTH)-1:0] loc_adr_i,
  output logic [7:0]               loc_dat_o,
  output logic                     wr_stb_o,
  output logic                     cmd_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;
  logic cs_armed;

  logic [2:0]    bit_cnt;
  logic [6:0]    rx_shift;
  logic [7:0]    tx_shift;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic          wr_mode;
  logic [7:0]    regs [DEPTH];

  logic       sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done;
  logic [7:0] rx_byte;

  // Input synchronizers; CS flops reset to "selected" so a pin already low at
  // reset release cannot look like a fresh falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_p0  <= 1'b0;
      sclk_p1  <= 1'b0;
      sclk_p2  <= 1'b0;
      cs_p0    <= 1'b0;
      cs_p1    <= 1'b0;
      cs_p2    <= 1'b0;
      mosi_p0  <= 1'b0;
      mosi_p1  <= 1'b0;
      cs_armed <= 1'b0;
    end else begin
      sclk_p0  <= spi_sclk_i;
      sclk_p1  <= sclk_p0;
      sclk_p2  <= sclk_p1;
      cs_p0    <= spi_cs_n_i;
      cs_p1    <= cs_p0;
      cs_p2    <= cs_p1;
      mosi_p0  <= spi_mosi_i;
      mosi_p1  <= mosi_p0;
      cs_armed <= cs_armed | cs_p1;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign cs_rise   = cs_p1 & ~cs_p2;
  assign cs_fall   = ~cs_p1 & cs_p2;
  assign rx_byte   = {rx_shift, mosi_p1};
  assign addr_nxt  = addr + AW'(1);
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_rise && (state_q != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE) begin
      if (cs_fall) state_d = S_CMD;
    end else if (byte_done) begin
      case (state_q)
        S_CMD:   state_d = (rx_byte == 8'h02 || rx_byte == 8'h03) ? S_ADDR : S_IGNORE;
        S_ADDR:  state_d = S_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  // Shift datapath and register file; tx_shift reloads at every byte boundary
  // so its MSB is ready before the next byte's first rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 8'h00;
      addr      <= '0;
      wr_mode   <= 1'b0;
      wr_stb_o  <= 1'b0;
      cmd_err_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_stb_o  <= 1'b0;
      cmd_err_o <= 1'b0;
      if (cs_rise) begin
        bit_cnt <= 3'd0;
      end else if (state_q == S_IDLE) begin
        if (cs_fall) begin
          bit_cnt  <= 3'd0;
          tx_shift <= 8'h00;
        end
      end else if (sclk_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          tx_shift <= 8'h00;
          case (state_q)
            S_CMD: begin
              wr_mode   <= (rx_byte == 8'h02);
              cmd_err_o <= (rx_byte != 8'h02) && (rx_byte != 8'h03);
            end
            S_ADDR: begin
              addr <= rx_byte[AW-1:0];
              if (!wr_mode) tx_shift <= regs[rx_byte[AW-1:0]];
            end
            S_DATA: begin
              addr <= addr_nxt;
              if (wr_mode) begin
                regs[addr] <= rx_byte;
                wr_stb_o   <= 1'b1;
              end else begin
                tx_shift <= regs[addr_nxt];
              end
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && bit_cnt != 3'd0) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign spi_miso_oe_o = ~cs_p1 & cs_armed;
  assign spi_miso_o    = spi_miso_oe_o & tx_shift[7];
  assign loc_dat_o     = regs[loc_adr_i];

endmodule

// File: tb/tb_ecap5_spi_target.sv
// Directed bench for ecap5_spi_target: MISO bytes are checked by a scoreboard
// monitor; register contents and strobe counts are checked after each frame.
module tb_ecap5_spi_target;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       spi_sclk_i, spi_cs_n_i, spi_mosi_i;
  logic       spi_miso_o, spi_miso_oe_o;
  logic [3:0] loc_adr_i;
  logic [7:0] loc_dat_o;
  logic       wr_stb_o, cmd_err_o;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  ecap5_spi_target #(.DEPTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .spi_sclk_i   (spi_sclk_i),
    .spi_cs_n_i   (spi_cs_n_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .loc_adr_i    (loc_adr_i),
    .loc_dat_o    (loc_dat_o),
    .wr_stb_o     (wr_stb_o),
    .cmd_err_o    (cmd_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_stb_o === 1'b1) stb_cnt++;
    if (cmd_err_o === 1'b1) err_cnt++;
  end

  // MISO scoreboard: assemble bytes on SCLK rising edges while selected.
  initial begin
    logic [7:0] sh;
    logic [7:0] e;
    int nb;
    nb = 0;
    sh = 8'h00;
    forever begin
      @(posedge spi_sclk_i or posedge spi_cs_n_i or posedge rst_i);
      if (spi_cs_n_i === 1'b1 || rst_i === 1'b1) begin
        nb = 0;
      end else if (spi_sclk_i === 1'b1) begin
        sh = {sh[6:0], spi_miso_o};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            check("miso_unexpected_byte", {24'd0, sh}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("miso_byte", {24'd0, sh}, {24'd0, e});
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi_i = b[7-i];
      wait_clk(6);
      spi_sclk_i = 1'b1;
      wait_clk(6);
      spi_sclk_i = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] exp_miso);
    exp_q.push_back(exp_miso);
    spi_bits(b, 8);
  endtask

  task automatic cs_low();
    spi_cs_n_i = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high();
    wait_clk(6);
    spi_cs_n_i = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_loc(input logic [3:0] adr, input logic [7:0] exp);
    loc_adr_i = adr;
    #1;
    check($sformatf("loc_dat[%0d]", adr), {24'd0, loc_dat_o}, {24'd0, exp});
  endtask

  initial begin
    int base_stb, base_err;
    rst_i      = 1'b1;
    spi_sclk_i = 1'b0;
    spi_cs_n_i = 1'b1;
    spi_mosi_i = 1'b0;
    loc_adr_i  = 4'd0;
    wait_clk(3);
    rst_i = 1'b0;
    wait_clk(4);

    check("reset_miso", {31'd0, spi_miso_o}, 32'd0);
    check("reset_oe", {31'd0, spi_miso_oe_o}, 32'd0);
    check("reset_wr_stb", {31'd0, wr_stb_o}, 32'd0);
    check("reset_cmd_err", {31'd0, cmd_err_o}, 32'd0);
    check_loc(4'd0, 8'h00);

    // Write burst
    base_stb = stb_cnt;
    cs_low();
    check("oe_selected", {31'd0, spi_miso_oe_o}, 32'd1);
    send(8'h02, 8'h00);
    send(8'h05, 8'h00);
    send(8'hA1, 8'h00);
    send(8'hB2, 8'h00);
    send(8'hC3, 8'h00);
    cs_high();
    check("oe_deselected", {31'd0, spi_miso_oe_o}, 32'd0);
    check("write_stb_count", stb_cnt - base_stb, 3);
    check_loc(4'd6, 8'hB2);
    check_loc(4'd5, 8'hA1);
    check_loc(4'd7, 8'hC3);
    check_loc(4'd4, 8'h00);
    check_loc(4'd8, 8'h00);

    // Read burst
    base_stb = stb_cnt;
    cs_low();
    send(8'h03, 8'h00);
    send(8'h05, 8'h00);
    send(8'h00, 8'hA1);
    check("oe_mid_read", {31'd0, spi_miso_oe_o}, 32'd1);
    send(8'h00, 8'hB2);
    send(8'h00, 8'hC3);
    cs_high();
    check("oe_after_read", {31'd0, spi_miso_oe_o}, 32'd0);
    check("read_stb_count", stb_cnt - base_stb, 0);

    // Wrap-around
    base_stb = stb_cnt;
    cs_low();
    send(8'h02, 8'h00);
    send(8'h0F, 8'h00);
    send(8'h11, 8'h00);
    send(8'h22, 8'h00);
    cs_high();
    check("wrap_stb_count", stb_cnt - base_stb, 2);
    check_loc(4'd15, 8'h11);
    check_loc(4'd0, 8'h22);
    cs_low();
    send(8'h03, 8'h00);
    send(8'h0F, 8'h00);
    send(8'h00, 8'h11);
    send(8'h00, 8'h22);
    cs_high();

    // Seed regs[3], then a bad command must leave it alone
    cs_low();
    send(8'h02, 8'h00);
    send(8'h03, 8'h00);
    send(8'h77, 8'h00);
    cs_high();
    check_loc(4'd3, 8'h77);
    base_stb = stb_cnt;
    base_err = err_cnt;
    cs_low();
    send(8'h7E, 8'h00);
    send(8'h03, 8'h00);
    send(8'h44, 8'h00);
    cs_high();
    check("bad_cmd_err_count", err_cnt - base_err, 1);
    check("bad_cmd_stb_count", stb_cnt - base_stb, 0);
    check_loc(4'd3, 8'h77);
    check_loc(4'd4, 8'h00);

    // Abort mid data byte
    base_stb = stb_cnt;
    cs_low();
    send(8'h02, 8'h00);
    send(8'h03, 8'h00);
    spi_bits(8'h99, 5);
    cs_high();
    check("abort_stb_count", stb_cnt - base_stb, 0);
    check_loc(4'd3, 8'h77);
    cs_low();
    send(8'h03, 8'h00);
    send(8'h03, 8'h00);
    send(8'h00, 8'h77);
    cs_high();

    // Reset during the data byte of a read
    cs_low();
    send(8'h03, 8'h00);
    send(8'h05, 8'h00);
    loc_adr_i = 4'd5;
    spi_bits(8'h00, 3);
    check_loc(4'd5, 8'hA1);
    @(posedge clk);
    #3 rst_i = 1'b1;
    #1;
    check("rst_async_miso", {31'd0, spi_miso_o}, 32'd0);
    check("rst_async_oe", {31'd0, spi_miso_oe_o}, 32'd0);
    check("rst_async_loc_dat", {24'd0, loc_dat_o}, 32'd0);
    check("rst_async_wr_stb", {31'd0, wr_stb_o}, 32'd0);
    @(posedge clk);
    #3 rst_i = 1'b0;
    wait_clk(2);
    base_stb = stb_cnt;
    send(8'h02, 8'h00);
    send(8'h05, 8'h00);
    send(8'h33, 8'h00);
    cs_high();
    check("post_rst_stb_count", stb_cnt - base_stb, 0);
    check_loc(4'd5, 8'h00);
    check_loc(4'd0, 8'h00);
    check_loc(4'd15, 8'h00);

    // Fresh frame works after CS cycled
    base_stb = stb_cnt;
    cs_low();
    send(8'h02, 8'h00);
    send(8'h01, 8'h00);
    send(8'h5A, 8'h00);
    cs_high();
    check("fresh_frame_stb_count", stb_cnt - base_stb, 1);
    check_loc(4'd1, 8'h5A);

    check("miso_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
